// File: rtl/l1_mem_arbiter_if.sv
// Bundle between the L1 cache controllers, the arbiter and main memory.
// slave: arbiter side; master: requester/memory side.
interface l1_mem_arbiter_if #(
  parameter int ADDR_W     = 28,
  parameter int BLOCK_BITS = 128
);
  logic                  iMemRen;
  logic [ADDR_W-1:0]     iBlockAddr;
  logic                  iMemReadReady;
  logic [BLOCK_BITS-1:0] iMemDout;
  logic                  dMemRen;
  logic                  dMemWen;
  logic [ADDR_W-1:0]     dBlockAddr;
  logic [BLOCK_BITS-1:0] dMemDin;
  logic                  dMemReadReady;
  logic                  dMemWriteDone;
  logic [BLOCK_BITS-1:0] dMemDout;
  logic                  memRen;
  logic                  memWen;
  logic [ADDR_W-1:0]     memBlockAddr;
  logic [BLOCK_BITS-1:0] memDin;
  logic                  memReadReady;
  logic                  memWriteDone;
  logic [BLOCK_BITS-1:0] memDout;
  logic [1:0]            grant;

  modport slave (
    input  iMemRen, iBlockAddr,
    input  dMemRen, dMemWen, dBlockAddr, dMemDin,
    input  memReadReady, memWriteDone, memDout,
    output iMemReadReady, iMemDout,
    output dMemReadReady, dMemWriteDone, dMemDout,
    output memRen, memWen, memBlockAddr, memDin,
    output grant
  );

  modport master (
    output iMemRen, iBlockAddr,
    output dMemRen, dMemWen, dBlockAddr, dMemDin,
    output memReadReady, memWriteDone, memDout,
    input  iMemReadReady, iMemDout,
    input  dMemReadReady, dMemWriteDone, dMemDout,
    input  memRen, memWen, memBlockAddr, memDin,
    input  grant
  );
endinterface

// File: rtl/l1_mem_arbiter.sv
// icache/dcache arbiter for the single main-memory block port.
// Define ARB_ROUND_ROBIN_EN for round-robin on conflicts (default: dcache first).
module l1_mem_arbiter (
  input logic        clock,
  input logic        reset,
  l1_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   dop_wr_q, dop_wr_d;
  logic   d_pend, i_pend, pick_d;

  assign d_pend = bus.dMemRen | bus.dMemWen;
  assign i_pend = bus.iMemRen;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;
  // On a conflict the side that did not win last time goes first
  assign pick_d = d_pend & (~i_pend | ~last_d_q);
`else
  assign pick_d = d_pend;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      dop_wr_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dop_wr_q <= dop_wr_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    dop_wr_d = dop_wr_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d  = SERVE_D;
          // Read+write together is illegal; the write wins
          dop_wr_d = bus.dMemWen;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b1;
`endif
        end else if (i_pend) begin
          state_d  = SERVE_I;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b0;
`endif
        end
      end
      SERVE_I: begin
        if (bus.memReadReady) state_d = IDLE;
      end
      SERVE_D: begin
        if (dop_wr_q ? bus.memWriteDone
                     : bus.memReadReady)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.iMemReadReady = 1'b0;
    bus.iMemDout      = '0;
    bus.dMemReadReady = 1'b0;
    bus.dMemWriteDone = 1'b0;
    bus.dMemDout      = '0;
    bus.memRen        = 1'b0;
    bus.memWen        = 1'b0;
    bus.memBlockAddr  = '0;
    bus.memDin        = '0;
    bus.grant         = 2'b00;
    unique case (state_q)
      SERVE_I: begin
        bus.grant         = 2'b01;
        bus.memRen        = 1'b1;
        bus.memBlockAddr  = bus.iBlockAddr;
        bus.iMemReadReady = bus.memReadReady;
        bus.iMemDout      = bus.memDout;
      end
      SERVE_D: begin
        bus.grant        = 2'b10;
        bus.memRen       = ~dop_wr_q;
        bus.memWen       = dop_wr_q;
        bus.memBlockAddr = bus.dBlockAddr;
        bus.memDin       = bus.dMemDin;
        if (dop_wr_q) begin
          bus.dMemWriteDone = bus.memWriteDone;
        end else begin
          bus.dMemReadReady = bus.memReadReady;
          bus.dMemDout      = bus.memDout;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Scoreboard bench for l1_mem_arbiter: expected commands/responses are
// queued by the stimulus and popped by negedge monitors.
module tb_l1_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l1_mem_arbiter_if #(.ADDR_W(28), .BLOCK_BITS(128)) bus ();

  l1_mem_arbiter dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [1:0]   g;
    logic         ren;
    logic         wen;
    logic [27:0]  a;
    logic [127:0] din;
  } cmd_t;

  typedef struct {
    logic [2:0]   kind;
    logic [127:0] data;
  } resp_t;

  localparam logic [2:0] K_I  = 3'b100;
  localparam logic [2:0] K_DR = 3'b010;
  localparam logic [2:0] K_DW = 3'b001;

  localparam logic [127:0] D_WB = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] D_1  = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] D_2  = 128'h22222222_22222222_22222222_22222222;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];
  int    n_pass = 0;
  int    n_tot  = 0;
  bit    last_d = 1'b0;
  logic [1:0] prev_g = 2'b00;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_cmd(input bit is_d, input bit wr,
                         input logic [27:0] a, input logic [127:0] din);
    cmd_t c;
    c.g = is_d ? 2'b10 : 2'b01;
    c.ren = ~wr;
    c.wen = wr;
    c.a = a;
    c.din = din;
    cmd_q.push_back(c);
  endtask

  task automatic exp_resp(input logic [2:0] k, input logic [127:0] d);
    resp_t r;
    r.kind = k;
    r.data = d;
    resp_q.push_back(r);
  endtask

  task automatic mem_respond(input bit wr, input int lat,
                             input logic [127:0] d);
    int n = 0;
    while (!(bus.memRen || bus.memWen) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("cmd_timeout", 1'b1, 1'b0);
    repeat (lat) tick();
    if (wr) bus.memWriteDone = 1'b1;
    else begin
      bus.memReadReady = 1'b1;
      bus.memDout = d;
    end
    tick();
    bus.memWriteDone = 1'b0;
    bus.memReadReady = 1'b0;
    bus.memDout = '0;
  endtask

  task automatic wait_grant(input logic [1:0] g);
    int n = 0;
    while (bus.grant !== g && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("grant_timeout", bus.grant, g);
  endtask

  // Command monitor: checks the memory command at the start of each grant
  always @(negedge clk) begin
    if (bus.grant != 2'b00 && prev_g == 2'b00) begin
      if (cmd_q.size() == 0) chk("unexpected_cmd", bus.grant, 2'b00);
      else begin
        cmd_t c;
        c = cmd_q.pop_front();
        chk("cmd_grant", bus.grant, c.g);
        chk("cmd_ren", bus.memRen, c.ren);
        chk("cmd_wen", bus.memWen, c.wen);
        chk("cmd_addr", bus.memBlockAddr, c.a);
        chk("cmd_din", bus.memDin, c.din);
      end
    end else if (bus.grant == 2'b00 && prev_g != 2'b00) begin
      chk("bubble_cmd", {bus.memRen, bus.memWen}, 2'b00);
    end
    prev_g = bus.grant;
  end

  // Response monitor: every ready/done pulse must match the queue head
  always @(negedge clk) begin
    logic [2:0] k;
    k = {bus.iMemReadReady, bus.dMemReadReady, bus.dMemWriteDone};
    if (k != 3'b000) begin
      if (resp_q.size() == 0) chk("unexpected_resp", k, 3'b000);
      else begin
        resp_t r;
        r = resp_q.pop_front();
        chk("resp_kind", k, r.kind);
        if (r.kind == K_I) begin
          chk("iMemDout", bus.iMemDout, r.data);
          chk("dMemDout_iso", bus.dMemDout, '0);
        end else if (r.kind == K_DR) begin
          chk("dMemDout", bus.dMemDout, r.data);
          chk("iMemDout_iso", bus.iMemDout, '0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end

  initial begin
    bus.iMemRen = 1'b0;
    bus.iBlockAddr = '0;
    bus.dMemRen = 1'b0;
    bus.dMemWen = 1'b0;
    bus.dBlockAddr = '0;
    bus.dMemDin = '0;
    bus.memReadReady = 1'b0;
    bus.memWriteDone = 1'b0;
    bus.memDout = '0;

    // 1: reset state, then first icache grant
    bus.iMemRen = 1'b1;
    bus.iBlockAddr = 28'h0000123;
    #2;
    chk("rst_grant", bus.grant, 2'b00);
    chk("rst_memRen", bus.memRen, 1'b0);
    chk("rst_all_zero",
        |{bus.iMemReadReady, bus.iMemDout, bus.dMemReadReady,
          bus.dMemWriteDone, bus.dMemDout, bus.memRen, bus.memWen,
          bus.memBlockAddr, bus.memDin, bus.grant}, 1'b0);
    exp_cmd(1'b0, 1'b0, 28'h0000123, '0);
    exp_resp(K_I, D_2);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_grant", bus.grant, 2'b01);
    last_d = 1'b0;
    mem_respond(1'b0, 2, D_2);
    bus.iMemRen = 1'b0;

    // 2: dcache writeback
    bus.dMemWen = 1'b1;
    bus.dBlockAddr = 28'h00000AB;
    bus.dMemDin = D_WB;
    exp_cmd(1'b1, 1'b1, 28'h00000AB, D_WB);
    exp_resp(K_DW, '0);
    mem_respond(1'b1, 5, '0);
    last_d = 1'b1;
    bus.dMemWen = 1'b0;
    bus.dMemDin = '0;
    chk("t2_idle_after", bus.grant, 2'b00);

    // 3: simultaneous requests, each drops after its completion
    bus.iMemRen = 1'b1;
    bus.iBlockAddr = 28'h0000200;
    bus.dMemRen = 1'b1;
    bus.dBlockAddr = 28'h0000300;
    for (int k = 0; k < 2; k++) begin
      bit win_d;
      if (k == 0) win_d = RR ? ~last_d : 1'b1;
      else win_d = bus.dMemRen;
      if (win_d) begin
        exp_cmd(1'b1, 1'b0, 28'h0000300, '0);
        exp_resp(K_DR, D_1);
        mem_respond(1'b0, 2, D_1);
        bus.dMemRen = 1'b0;
      end else begin
        exp_cmd(1'b0, 1'b0, 28'h0000200, '0);
        exp_resp(K_I, D_2);
        mem_respond(1'b0, 2, D_2);
        bus.iMemRen = 1'b0;
      end
      last_d = win_d;
    end

    // 5: wrong-type completion during a dcache read is ignored
    bus.dMemRen = 1'b1;
    bus.dBlockAddr = 28'h00000F0;
    exp_cmd(1'b1, 1'b0, 28'h00000F0, '0);
    exp_resp(K_DR, D_1);
    wait_grant(2'b10);
    tick();
    bus.memWriteDone = 1'b1;
    tick();
    bus.memWriteDone = 1'b0;
    tick();
    chk("t5_still_d", bus.grant, 2'b10);
    mem_respond(1'b0, 1, D_1);
    bus.dMemRen = 1'b0;
    last_d = 1'b1;

    // 6: async reset mid icache read, then re-grant
    bus.iMemRen = 1'b1;
    bus.iBlockAddr = 28'h0000456;
    exp_cmd(1'b0, 1'b0, 28'h0000456, '0);
    wait_grant(2'b01);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_memRen", bus.memRen, 1'b0);
    chk("t6_rst_grant", bus.grant, 2'b00);
    tick();
    rst_n = 1'b1;
    exp_cmd(1'b0, 1'b0, 28'h0000456, '0);
    exp_resp(K_I, D_2);
    tick();
    chk("t6_regrant", bus.grant, 2'b01);
    mem_respond(1'b0, 2, D_2);
    bus.iMemRen = 1'b0;
    last_d = 1'b0;

    // 4: three back-to-back conflicts with both requests held
    bus.iMemRen = 1'b1;
    bus.iBlockAddr = 28'h00003B0;
    bus.dMemRen = 1'b1;
    bus.dBlockAddr = 28'h00003A0;
    for (int k = 0; k < 3; k++) begin
      bit win_d;
      win_d = RR ? ~last_d : 1'b1;
      if (win_d) begin
        exp_cmd(1'b1, 1'b0, 28'h00003A0, '0);
        exp_resp(K_DR, D_1);
        mem_respond(1'b0, 1, D_1);
      end else begin
        exp_cmd(1'b0, 1'b0, 28'h00003B0, '0);
        exp_resp(K_I, D_2);
        mem_respond(1'b0, 1, D_2);
      end
      last_d = win_d;
    end
    bus.iMemRen = 1'b0;
    bus.dMemRen = 1'b0;

    repeat (3) tick();
    chk("final_idle", bus.grant, 2'b00);
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
Shares the single main-memory block port between the icache controller (reads only) and the dcache controller (block reads and dirty writebacks).
- Sits between both L1 cache controllers and the memory model.
- Grants one requester at a time and holds the grant until the memory completion pulse.
- Routes memory responses only to the granted requester.

Parameters:
ADDR_W, 28, block address width (32-bit address minus 4-bit block offset)
BLOCK_BITS, 128, block data width in bits

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
iMemRen  in  1  icache block read request (level, held until iMemReadReady)
iBlockAddr  in  ADDR_W  icache block address
iMemReadReady  out  1  read-complete pulse to icache
iMemDout  out  BLOCK_BITS  read data to icache
dMemRen  in  1  dcache block read request (level)
dMemWen  in  1  dcache block write request (level)
dBlockAddr  in  ADDR_W  dcache block address
dMemDin  in  BLOCK_BITS  dcache writeback data
dMemReadReady  out  1  read-complete pulse to dcache
dMemWriteDone  out  1  write-complete pulse to dcache
dMemDout  out  BLOCK_BITS  read data to dcache
memRen  out  1  memory read command
memWen  out  1  memory write command
memBlockAddr  out  ADDR_W  memory block address
memDin  out  BLOCK_BITS  memory write data
memReadReady  in  1  memory read-complete pulse
memWriteDone  in  1  memory write-complete pulse
memDout  in  BLOCK_BITS  memory read data
grant  out  2  one-hot current owner: [0]=icache, [1]=dcache; 00 when idle

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; dOpWrite cleared; lastGrant set to icache.
  - All outputs are 0.
  - A reset mid-transaction abandons it; the memory model is responsible for its own abort.
- States: IDLE, SERVE_I, SERVE_D. Registered state; outputs are decoded combinationally from the state.
- IDLE:
  - No memory command; grant=00; all requester-side ready/done outputs are 0.
  - Arbitration at the clock edge:
    - only dcache pending (dMemRen|dMemWen) -> SERVE_D
    - only iMemRen -> SERVE_I
    - both pending -> SERVE_D (fixed priority, default build)
    - none -> stay in IDLE
  - On entry to SERVE_D, latch dOpWrite = dMemWen. If dMemRen and dMemWen are both 1, this is illegal but is treated as a write.
- SERVE_I:
  - memRen=1, memBlockAddr=iBlockAddr, grant=01.
  - iMemReadReady=memReadReady; iMemDout=memDout.
  - memReadReady=1 -> IDLE at the next edge.
- SERVE_D:
  - memRen=~dOpWrite, memWen=dOpWrite, memBlockAddr=dBlockAddr, memDin=dMemDin, grant=10.
  - Read op: dMemReadReady=memReadReady, dMemDout=memDout; completes on memReadReady.
  - Write op: dMemWriteDone=memWriteDone; completes on memWriteDone.
  - On completion -> IDLE.
- Response isolation:
  - The non-granted requester's ready/done outputs are forced to 0; its data output is 0.
  - A completion pulse of the wrong type is ignored (e.g. memWriteDone while serving a read).
- Latency:
  - Request seen in IDLE at edge N -> memory command asserted in cycle N+1.
  - Completion pulse at edge M -> IDLE in cycle M+1 (one bubble cycle).
  - Earliest re-grant: edge M+1.
- Dcache miss sequence: writeback done -> IDLE bubble -> the dcache read request is re-arbitrated. Under fixed priority, the icache cannot interleave.
- A requester dropping its request while granted does not release the grant; the arbiter waits for the memory completion.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: when both are pending in IDLE, grant the requester not in lastGrant.
  - lastGrant updates on every grant.
  - Reset value (icache) means the first conflict goes to the dcache.
  - The icache may be served between a dcache writeback and its refill read.
- Undefined: fixed dcache priority; the lastGrant register is not present.

Test Plan:
1. Reset low with iMemRen=1 -> grant=00, memRen=0, all outputs 0. Release reset, next edge -> grant=01, memRen=1, memBlockAddr=iBlockAddr=0x0000123.
2. dMemWen=1, dBlockAddr=0x00000AB, dMemDin=128'hDEAD...BEEF; memWriteDone after 5 cycles -> memWen=1 for those cycles with matching address/data, dMemWriteDone pulses 1 cycle, iMemReadReady stays 0, state IDLE one cycle later.
3. iMemRen and dMemRen both asserted in IDLE, default build -> grant=10 first; after memReadReady and the bubble -> grant=01. Data 128'h1111... goes only to dMemDout, then 128'h2222... only to iMemDout.
4. Same as 3 with ARB_ROUND_ROBIN_EN, three back-to-back conflicts -> grant order 10, 01, 10.
5. In SERVE_D read, memWriteDone=1 pulse injected -> ignored, stays in SERVE_D until memReadReady; dMemWriteDone stays 0.
6. Reset dropped to 0 mid SERVE_I, 2 cycles before memReadReady -> memRen falls immediately (async), grant=00; after release, iMemRen is still high -> re-granted the next edge.
